// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM: fetch/decode/exec/mem/wb sequencing.
// Optional IMM_EXT_EN macro adds addi/andi/ori immediate instructions.
module multicycle_control #(
    parameter int ALU_OP_W = 2,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [5:0]          opcode,
    output logic                reg_dst,
    output logic                memto_reg,
    output logic                jump,
    output logic                branch,
    output logic                mem_read,
    output logic                mem_write,
    output logic                alu_src,
    output logic                reg_write,
    output logic                sign_or_zero,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                ir_write,
    output logic                pc_write,
    output logic                iord,
    output logic                busy,
    output logic                done,
    output logic                illegal,
    output logic [CNT_W-1:0]    instr_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    state_t     state, nxt;
    logic [5:0] op_q;
    logic [1:0] alu2;
    logic       in_legal;
    logic       in_imm;
    logic       op_r, op_lw, op_sw, op_beq, op_j, op_imm, op_addi;

`ifdef IMM_EXT_EN
    assign in_imm  = (opcode == OP_ADDI) || (opcode == OP_ANDI) ||
                     (opcode == OP_ORI);
    assign op_imm  = (op_q == OP_ADDI) || (op_q == OP_ANDI) ||
                     (op_q == OP_ORI);
`else
    assign in_imm  = 1'b0;
    assign op_imm  = 1'b0;
`endif

    assign in_legal = (opcode == OP_R) || (opcode == OP_LW) ||
                      (opcode == OP_SW) || (opcode == OP_BEQ) ||
                      (opcode == OP_J) || in_imm;

    assign op_r    = (op_q == OP_R);
    assign op_lw   = (op_q == OP_LW);
    assign op_sw   = (op_q == OP_SW);
    assign op_beq  = (op_q == OP_BEQ);
    assign op_j    = (op_q == OP_J);
    assign op_addi = (op_q == OP_ADDI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            op_q        <= '0;
            instr_count <= '0;
        end else begin
            state <= nxt;
            if (state == S_DECODE)
                op_q <= opcode;
            if (done && !illegal)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    always_comb begin
        nxt          = state;
        reg_dst      = 1'b0;
        memto_reg    = 1'b0;
        jump         = 1'b0;
        branch       = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        alu_src      = 1'b0;
        reg_write    = 1'b0;
        sign_or_zero = 1'b1;
        alu2         = 2'b00;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        iord         = 1'b0;
        busy         = (state != S_IDLE);
        done         = 1'b0;
        illegal      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start)
                    nxt = S_FETCH;
            end
            S_FETCH: begin
                mem_read = 1'b1;
                ir_write = 1'b1;
                pc_write = 1'b1;
                nxt      = S_DECODE;
            end
            S_DECODE: begin
                if (in_legal) begin
                    nxt = S_EXEC;
                end else begin
                    illegal = 1'b1;
                    done    = 1'b1;
                    nxt     = S_IDLE;
                end
            end
            S_EXEC: begin
                unique case (1'b1)
                    op_r: nxt = S_WB;
                    op_lw, op_sw: begin
                        alu_src = 1'b1;
                        alu2    = 2'b11;
                        nxt     = S_MEM;
                    end
                    op_beq: begin
                        alu2   = 2'b01;
                        branch = 1'b1;
                        done   = 1'b1;
                    end
                    op_j: begin
                        jump     = 1'b1;
                        pc_write = 1'b1;
                        done     = 1'b1;
                    end
                    op_imm: begin
                        alu_src      = 1'b1;
                        alu2         = 2'b10;
                        sign_or_zero = op_addi;
                        nxt          = S_WB;
                    end
                    default: nxt = S_IDLE;
                endcase
            end
            S_MEM: begin
                iord    = 1'b1;
                alu_src = 1'b1;
                alu2    = 2'b11;
                unique case (1'b1)
                    op_lw: begin
                        mem_read = 1'b1;
                        nxt      = S_WB;
                    end
                    op_sw: begin
                        mem_write = 1'b1;
                        done      = 1'b1;
                    end
                    default: nxt = S_IDLE;
                endcase
            end
            S_WB: begin
                reg_write = 1'b1;
                done      = 1'b1;
                unique case (1'b1)
                    op_r:  reg_dst   = 1'b1;
                    op_lw: memto_reg = 1'b1;
                    op_imm: begin
                        alu_src      = 1'b1;
                        alu2         = 2'b10;
                        sign_or_zero = op_addi;
                    end
                    default: begin
                        reg_write = 1'b0;
                        done      = 1'b0;
                        nxt       = S_IDLE;
                    end
                endcase
            end
            default: nxt = S_IDLE;
        endcase
        // legal completion chains straight into the next fetch when requested
        if (done && !illegal)
            nxt = start ? S_FETCH : S_IDLE;
    end

    assign alu_op = ALU_OP_W'(alu2);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control with packed-control checks.
// A second CNT_W=2 instance exercises counter wrap.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  opcode = 6'b0;
    logic        reg_dst, memto_reg, jump, branch, mem_read, mem_write;
    logic        alu_src, reg_write, sign_or_zero, ir_write, pc_write, iord;
    logic        busy, done, illegal;
    logic [1:0]  alu_op;
    logic [15:0] instr_count;
    logic        b_reg_dst, b_memto_reg, b_jump, b_branch, b_mem_read;
    logic        b_mem_write, b_alu_src, b_reg_write, b_sz, b_ir_write;
    logic        b_pc_write, b_iord, b_busy, b_done, b_illegal;
    logic [1:0]  b_alu_op;
    logic [1:0]  b_count;

    int vecs = 0;
    int errs = 0;

    // bit order: reg_dst memto jump branch mrd mwr alu_src reg_wr sz irw pcw iord busy done ill alu_op[1:0]
    localparam logic [16:0] V_IDLE  = 17'h00100;
    localparam logic [16:0] V_FETCH = 17'h011D0;
    localparam logic [16:0] V_DEC   = 17'h00110;
    localparam logic [16:0] V_DILL  = 17'h0011C;
    localparam logic [16:0] V_EXR   = 17'h00110;
    localparam logic [16:0] V_EXM   = 17'h00513;
    localparam logic [16:0] V_EXBEQ = 17'h02119;
    localparam logic [16:0] V_EXJ   = 17'h04158;
    localparam logic [16:0] V_MEMLW = 17'h01533;
    localparam logic [16:0] V_MEMSW = 17'h00D3B;
    localparam logic [16:0] V_WBR   = 17'h10318;
    localparam logic [16:0] V_WBLW  = 17'h08318;
    localparam logic [16:0] V_EXIMM = 17'h00412;
    localparam logic [16:0] V_WBIMM = 17'h0061A;

    logic [16:0] ctl;
    assign ctl = {reg_dst, memto_reg, jump, branch, mem_read, mem_write,
                  alu_src, reg_write, sign_or_zero, ir_write, pc_write,
                  iord, busy, done, illegal, alu_op};

    always #5 clk = ~clk;

    multicycle_control u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .reg_dst(reg_dst), .memto_reg(memto_reg), .jump(jump),
        .branch(branch), .mem_read(mem_read), .mem_write(mem_write),
        .alu_src(alu_src), .reg_write(reg_write),
        .sign_or_zero(sign_or_zero), .alu_op(alu_op),
        .ir_write(ir_write), .pc_write(pc_write), .iord(iord),
        .busy(busy), .done(done), .illegal(illegal),
        .instr_count(instr_count)
    );

    multicycle_control #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .reg_dst(b_reg_dst), .memto_reg(b_memto_reg), .jump(b_jump),
        .branch(b_branch), .mem_read(b_mem_read),
        .mem_write(b_mem_write), .alu_src(b_alu_src),
        .reg_write(b_reg_write), .sign_or_zero(b_sz),
        .alu_op(b_alu_op), .ir_write(b_ir_write),
        .pc_write(b_pc_write), .iord(b_iord), .busy(b_busy),
        .done(b_done), .illegal(b_illegal), .instr_count(b_count)
    );

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [16:0] exp);
        vecs++;
        assert (ctl === exp) else begin
            errs++;
            $error("FAIL %s: ctl got %05h want %05h", tag, ctl, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [15:0] exp);
        vecs++;
        assert (instr_count === exp) else begin
            errs++;
            $error("FAIL %s: count got %0d want %0d", tag, instr_count, exp);
        end
    endtask

    task automatic chk_cnt2(input string tag, input logic [1:0] exp);
        vecs++;
        assert (b_count === exp) else begin
            errs++;
            $error("FAIL %s: count2 got %0d want %0d", tag, b_count, exp);
        end
    endtask

    initial begin
        @(negedge clk);
        chk("reset_ctl", V_IDLE);
        chk_cnt("reset_cnt", 16'd0);
        rst_n = 1'b1;

        // lw, opcode disturbed after decode
        start = 1'b1; opcode = 6'b100011;
        step(); chk("lw_fetch", V_FETCH);
        start = 1'b0;
        step(); chk("lw_decode", V_DEC);
        step(); chk("lw_exec", V_EXM);
        opcode = 6'b000000;
        step(); chk("lw_mem", V_MEMLW);
        step(); chk("lw_wb", V_WBLW);
        step(); chk("lw_idle", V_IDLE);
        chk_cnt("lw_cnt", 16'd1);

        // back-to-back R, sw, beq, j
        start = 1'b1; opcode = 6'b000000;
        step(); chk("r_c1", V_FETCH);
        step(); chk("r_c2", V_DEC);
        step(); chk("r_c3", V_EXR);
        step(); chk("r_c4", V_WBR);
        opcode = 6'b101011;
        step(); chk("sw_c5", V_FETCH);
        step(); chk("sw_c6", V_DEC);
        step(); chk("sw_c7", V_EXM);
        step(); chk("sw_c8", V_MEMSW);
        opcode = 6'b000100;
        step(); chk("beq_c9", V_FETCH);
        step(); chk("beq_c10", V_DEC);
        step(); chk("beq_c11", V_EXBEQ);
        opcode = 6'b000010;
        step(); chk("j_c12", V_FETCH);
        step(); chk("j_c13", V_DEC);
        step(); chk("j_c14", V_EXJ);
        start = 1'b0;
        step(); chk("b2b_idle", V_IDLE);
        chk_cnt("b2b_cnt", 16'd5);

        // illegal opcode
        start = 1'b1; opcode = 6'b111111;
        step(); chk("ill_fetch", V_FETCH);
        start = 1'b0;
        step(); chk("ill_decode", V_DILL);
        step(); chk("ill_idle", V_IDLE);
        chk_cnt("ill_cnt", 16'd5);

        // reset during sw MEM
        start = 1'b1; opcode = 6'b101011;
        step(); start = 1'b0;
        step(); step();
        step(); chk("rst_sw_mem", V_MEMSW);
        rst_n = 1'b0;
        #1 chk("rst_async", V_IDLE);
        chk_cnt("rst_cnt", 16'd0);
        chk_cnt2("rst_cnt2", 2'd0);
        #1 rst_n = 1'b1;

        // five R-types, wrap on CNT_W=2 copy
        start = 1'b1; opcode = 6'b000000;
        step();
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("wrap_f%0d", k), V_FETCH);
            step(); step(); step();
            chk($sformatf("wrap_wb%0d", k), V_WBR);
            if (k == 5) start = 1'b0;
            step();
            chk_cnt($sformatf("wrap_cnt%0d", k), 16'(k));
            chk_cnt2($sformatf("wrap_cnt2_%0d", k), 2'(k % 4));
        end
        chk("wrap_idle", V_IDLE);

        // andi
        start = 1'b1; opcode = 6'b001100;
        step(); chk("andi_fetch", V_FETCH);
        start = 1'b0;
`ifdef IMM_EXT_EN
        step(); chk("andi_decode", V_DEC);
        step(); chk("andi_exec", V_EXIMM);
        step(); chk("andi_wb", V_WBIMM);
        step(); chk("andi_idle", V_IDLE);
        chk_cnt("andi_cnt", 16'd6);
`else
        step(); chk("andi_decode", V_DILL);
        step(); chk("andi_idle", V_IDLE);
        chk_cnt("andi_cnt", 16'd5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim did not finish, want finish");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter ALU_OP_W, default 2: width of alu_op; legal range is >=2, and bits above [1:0] are driven 0.
REQ-002 Parameter CNT_W, default 16: width of instr_count.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  request to begin one instruction.
REQ-006 opcode  input  6  instruction opcode; valid during the DECODE state.
REQ-007 reg_dst, memto_reg, jump, branch, mem_read, mem_write, alu_src, reg_write, sign_or_zero  output  1 each  datapath controls.
REQ-008 alu_op  output  ALU_OP_W  ALU class: 00 add/R-type, 01 subtract/beq, 11 address add, 10 immediate.
REQ-009 ir_write, pc_write, iord  output  1 each  IR load, PC load, memory address select (0 = PC, 1 = ALU).
REQ-010 busy, done, illegal  output  1 each  FSM not in IDLE; last cycle of an instruction; unrecognised opcode.
REQ-011 instr_count  output  CNT_W  number of completed instructions.

Function
REQ-012 States: IDLE, FETCH, DECODE, EXEC, MEM, WB; outputs are a Moore decode of the state register plus the latched opcode op_q.
REQ-013 Default in every state: all 1-bit controls 0, sign_or_zero=1, alu_op=0.
REQ-014 IDLE: start=1 -> FETCH; otherwise stay in IDLE.
REQ-015 FETCH: mem_read=1, iord=0, ir_write=1, pc_write=1; next state DECODE.
REQ-016 DECODE: op_q loads opcode on the exit edge. Next state: 000000/100011/101011/000100/000010 -> EXEC; any other opcode -> illegal=1 and done=1 for this cycle, no instr_count increment, next state IDLE.
REQ-017 EXEC, R-type (000000): alu_op=00; next state WB.
REQ-018 EXEC, lw (100011) and sw (101011): alu_src=1, alu_op=11; next state MEM.
REQ-019 EXEC, beq (000100): alu_op=01, branch=1, done=1; instruction ends.
REQ-020 EXEC, j (000010): jump=1, pc_write=1, done=1; instruction ends.
REQ-021 MEM, lw: mem_read=1, iord=1, alu_src=1, alu_op=11; next state WB.
REQ-022 MEM, sw: mem_write=1, iord=1, alu_src=1, alu_op=11, done=1; instruction ends.
REQ-023 WB, R-type: reg_dst=1, reg_write=1, done=1.
REQ-024 WB, lw: memto_reg=1, reg_write=1, done=1.
REQ-025 Latency from FETCH entry to the done cycle, inclusive: beq 3, j 3, R-type 4, sw 4, lw 5 cycles.
REQ-026 In any done cycle: start=1 -> FETCH (back-to-back, no IDLE bubble); start=0 -> IDLE.
REQ-027 start is ignored in every non-IDLE, non-done cycle; it is not queued.
REQ-028 busy=1 in every state except IDLE.
REQ-029 instr_count increments by 1 on the exit edge of each legal done cycle; it wraps from 2^CNT_W-1 to 0.
REQ-030 opcode changes outside DECODE have no effect; only op_q drives EXEC, MEM and WB.

Reset
REQ-031 rst_n=0 immediately forces IDLE, op_q=0, instr_count=0, and all outputs to their REQ-013 defaults, with busy=done=illegal=0; this applies in any state, including mid-instruction.
REQ-032 After rst_n deasserts, the first start is accepted on the next rising edge with rst_n=1.

Configuration
REQ-033 Macro IMM_EXT_EN defined: opcodes 001000 (addi), 001100 (andi) and 001101 (ori) are legal.
- EXEC: alu_src=1, alu_op=10.
- WB: alu_src=1, reg_write=1, reg_dst=0, done=1 (latency 4).
- sign_or_zero=0 in EXEC and WB for andi/ori; 1 for addi.
REQ-034 Macro IMM_EXT_EN undefined: 001000, 001100 and 001101 are illegal per REQ-016.

Verification
REQ-035 Reset, then start=1 for one cycle with opcode=100011 -> states FETCH, DECODE, EXEC, MEM, WB; done high in cycle 5 only; memto_reg=reg_write=1 in WB; instr_count=1.
REQ-036 start held at 1, opcodes 000000, 101011, 000100, 000010 in turn -> done at cycles 4, 8, 11, 14; no IDLE between instructions; instr_count=4.
REQ-037 opcode=111111 -> illegal=done=1 in the DECODE cycle (cycle 2); IDLE next; instr_count unchanged.
REQ-038 rst_n pulsed low during MEM of an sw -> mem_write drops at once; state IDLE; instr_count=0.
REQ-039 CNT_W=2, five legal R-types -> instr_count sequence 1, 2, 3, 0, 1.
REQ-040 opcode=001100 -> with IMM_EXT_EN: WB reg_write=1, sign_or_zero=0, alu_op=10; without IMM_EXT_EN: illegal=1 at DECODE.
